// File: rtl/pe_pkg.sv
// Shared definitions for the PE-column output drain.
//   drain_state_t : drain FSM states
//   RND_K         : half-LSB rounding constant in accumulator units
//   MAX_Q / MIN_Q : clamp bounds of the MUL_BW-bit signed result
//   sat_round()   : accumulator -> rounded, saturated result plus clamp flag
package pe_pkg;

    localparam int INT_BW      = 5;
    localparam int FRA_BW      = 10;
    localparam int MUL_BW      = 1 + INT_BW + FRA_BW;
    localparam int ACC_BW      = 32;
    localparam int K_BW        = 8;
    localparam int DRAIN_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAP  = 2'd2,
        DONE = 2'd3
    } drain_state_t;

    localparam int MAX_I = 2 ** (MUL_BW - 1) - 1;
    localparam int MIN_I = -(2 ** (MUL_BW - 1));

    // Everything is evaluated one bit wider than the accumulator so the
    // rounding add can never wrap before the clamp sees it.
    localparam logic signed [ACC_BW:0] RND_K = (ACC_BW + 1)'(2 ** (FRA_BW - 1));
    localparam logic signed [ACC_BW:0] MAX_Q = (ACC_BW + 1)'(MAX_I);
    localparam logic signed [ACC_BW:0] MIN_Q = (ACC_BW + 1)'(MIN_I);

    typedef struct packed {
        logic [MUL_BW-1:0] val;
        logic              clamp;
    } sat_res_t;

    // Round half up by dropping FRA_BW of the 2*FRA_BW fraction bits, then
    // clamp to the output range.
    function automatic sat_res_t sat_round(input logic signed [ACC_BW-1:0] acc);
        logic signed [ACC_BW:0] sum;
        logic signed [ACC_BW:0] r;
        sat_res_t               res;
        sum = $signed({acc[ACC_BW-1], acc}) + RND_K;
        r   = sum >>> FRA_BW;
        if (r > MAX_Q) begin
            res.val   = MAX_Q[MUL_BW-1:0];
            res.clamp = 1'b1;
        end else if (r < MIN_Q) begin
            res.val   = MIN_Q[MUL_BW-1:0];
            res.clamp = 1'b1;
        end else begin
            res.val   = r[MUL_BW-1:0];
            res.clamp = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/drain_fifo.sv
// Show-ahead synchronous FIFO.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write request and data; ignored when full unless pop is also high
//   pop      : read request; ignored when empty
//   dout     : head entry (zero while empty)
//   full     : DEPTH entries held
//   empty    : no entries held
module drain_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit separates full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign do_push = push && (!full || pop);

    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pe_drain.sv
// Output drain below the bottom PE of one array column.
//   clk, rst     : clock, synchronous active-high reset
//   start_i      : pulse that begins a drain (accepted in IDLE only)
//   k_len_i      : skew cycles between start and first capture
//   n_out_i      : number of samples to capture
//   o_i          : signed accumulator stream from the bottom PE
//   res_o        : rounded/saturated result at FIFO head
//   res_valid_o  : FIFO non-empty
//   res_ready_i  : consumer accepts res_o
//   busy_o       : drain in progress (WAIT or CAP)
//   done_o       : one-cycle pulse after the last capture
//   ovf_o        : sticky, a capture was dropped on a full FIFO
//   sat_o        : sticky, a captured sample was clamped
// Output handshake: an entry transfers on every rising edge where
// res_valid_o and res_ready_i are both high; res_o holds until then.
module pe_drain
    import pe_pkg::*;
#(
    parameter int DEPTH = DRAIN_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [K_BW-1:0]   k_len_i,
    input  logic [K_BW-1:0]   n_out_i,
    input  logic [ACC_BW-1:0] o_i,
    output logic [MUL_BW-1:0] res_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ovf_o,
    output logic              sat_o
);

    drain_state_t    state;
    logic [K_BW-1:0] skew_cnt;
    logic [K_BW-1:0] samp_cnt;
    sat_res_t        conv;
    logic            cap;
    logic            pop;
    logic            full;
    logic            empty;

    assign conv        = sat_round(o_i);
    assign cap         = (state == CAP);
    assign res_valid_o = !empty;
    assign pop         = res_valid_o && res_ready_i;

    drain_fifo #(
        .WIDTH (MUL_BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cap),
        .pop   (pop),
        .din   (conv.val),
        .dout  (res_o),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            skew_cnt <= '0;
            samp_cnt <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            ovf_o    <= 1'b0;
            sat_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        skew_cnt <= k_len_i;
                        samp_cnt <= n_out_i;
                        ovf_o    <= 1'b0;
                        sat_o    <= 1'b0;
                        if (k_len_i != '0) begin
                            state  <= WAIT;
                            busy_o <= 1'b1;
                        end else if (n_out_i != '0) begin
                            state  <= CAP;
                            busy_o <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    skew_cnt <= skew_cnt - K_BW'(1);
                    // Leaving on the count-of-one edge makes the first
                    // capture land exactly k_len edges after start.
                    if (skew_cnt == K_BW'(1)) begin
                        if (samp_cnt != '0) begin
                            state <= CAP;
                        end else begin
                            state  <= DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end
                    end
                end
                CAP: begin
                    samp_cnt <= samp_cnt - K_BW'(1);
                    if (conv.clamp) sat_o <= 1'b1;
                    // The array cannot stall, so a full FIFO drops the sample.
                    if (full && !pop) ovf_o <= 1'b1;
                    if (samp_cnt == K_BW'(1)) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
